// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// data width and the default reset fetch address.
package fetch_unit_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   // Fetch addresses are always word aligned; low two bits are discarded.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one memory request,
// presents the returned word to decode and follows redirects from execute.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_inc;
   logic            drop;

   assign target        = word_align(redirect_pc);
   assign pc_inc        = pc + XLEN'(4);
   assign imem_req_addr = pc;

   // Drop marks an outstanding response that belongs to a squashed fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         imem_req_valid <= 1'b0;
         if_valid       <= 1'b0;
         if_pc          <= '0;
         if_instr       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect) pc <= target;
               state          <= S_REQ;
               imem_req_valid <= 1'b1;
            end

            S_REQ: begin
               if (redirect) pc <= target;
               if (imem_req_ready) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
                  drop           <= redirect;
               end
            end

            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop || redirect) begin
                     if (redirect) pc <= target;
                     drop           <= 1'b0;
                     state          <= S_REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     if_pc    <= pc;
                     if_instr <= imem_rsp_data;
                     if_valid <= 1'b1;
                     state    <= S_HOLD;
                  end
               end else if (redirect) begin
                  pc   <= target;
                  drop <= 1'b1;
               end
            end

            S_HOLD: begin
               // A redirect squashes the held word even if decode takes it.
               if (redirect) begin
                  pc             <= target;
                  if_valid       <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end else if (if_ready) begin
                  pc             <= pc_inc;
                  if_valid       <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
